mbgd_err_accum: RTL and testbench



---
 rtl/mbgd_pkg.sv | 30 +++
 rtl/mbgd_lane_acc.sv | 41 ++++
 rtl/mbgd_err_accum.sv | 102 ++++++++++
 tb/tb_mbgd_err_accum.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbgd_pkg.sv
// Shared types and width helpers for the MBGD error-accumulation stage.
package mbgd_pkg;

    // Default geometry of the datapath
    localparam int DEF_N     = 8;
    localparam int DEF_DW    = 8;
    localparam int DEF_BATCH = 16;

    // Batch controller states
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Accumulator width: exact difference (DW+1) plus headroom for BATCH rows
    function automatic int calc_aw(input int dw, input int batch);
        return dw + 1 + $clog2(batch);
    endfunction

    // Row-count width able to hold the value BATCH itself
    function automatic int calc_cw(input int batch);
        return $clog2(batch + 1);
    endfunction

    // Low bit index of lane 'lane' in a packed vector of w-bit lanes
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mbgd_lane_acc.sv
// One lane of the error accumulator: exact H-Y difference, sign-extended and
// summed across the rows of a mini-batch.
module mbgd_lane_acc
    import mbgd_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = calc_aw(DEF_DW, DEF_BATCH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          en,
    input  logic          first,
    input  logic [DW-1:0] h,
    input  logic [DW-1:0] y,
    output logic [AW-1:0] acc_nxt
);

    logic [AW-1:0] acc;
    logic [DW:0]   diff;
    logic [AW-1:0] diff_ext;

    // Widen by one bit before subtracting so the difference never wraps
    always_comb begin
        diff     = {h[DW-1], h} - {y[DW-1], y};
        diff_ext = {{(AW-DW-1){diff[DW]}}, diff};
        acc_nxt  = first ? diff_ext : acc + diff_ext;
    end

    // The first row of a batch loads instead of adding, so no stale sum leaks in
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/mbgd_err_accum.sv
// Mini-batch error accumulator: sums H-Y per lane over up to BATCH rows and
// presents the sums with a valid/ready handshake.
module mbgd_err_accum
    import mbgd_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int BATCH = DEF_BATCH,
    parameter int CW    = calc_cw(BATCH),
    parameter int AW    = calc_aw(DW, BATCH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [N*DW-1:0] inp_h,
    input  logic [N*DW-1:0] inp_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*AW-1:0] err_sum,
    output logic [CW-1:0]   row_count
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            close;
    logic            lane_en;
    logic            first_row;
    logic [N*AW-1:0] sum_nxt;

    // Handshake decode; clear suppresses the lane update of a colliding row
    always_comb begin
        accept    = in_valid && in_ready && (state == ACCUM);
        close     = accept && (in_last || (cnt == CW'(BATCH - 1)));
        lane_en   = accept && !clear;
        first_row = (cnt == '0);
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mbgd_lane_acc #(
            .DW (DW),
            .AW (AW)
        ) u_lane (
            .clk     (clk),
            .resetn  (resetn),
            .clear   (clear),
            .en      (lane_en),
            .first   (first_row),
            .h       (inp_h[lane_lo(i, DW) +: DW]),
            .y       (inp_y[lane_lo(i, DW) +: DW]),
            .acc_nxt (sum_nxt[lane_lo(i, AW) +: AW])
        );
    end

    // Batch FSM: counts rows, latches the sums on close and holds them until taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ACCUM;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err_sum   <= '0;
            row_count <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (close) begin
                        err_sum   <= sum_nxt;
                        row_count <= cnt + CW'(1);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        state     <= HOLD;
                    end else if (accept) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbgd_err_accum.sv
// Self-checking bench for mbgd_err_accum (N=8, DW=8, BATCH=4) with a
// row-level reference model and directed literal checks.
module tb_mbgd_err_accum;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int BATCH = 4;
    localparam int CW    = 3;
    localparam int AW    = 11;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] inp_h = '0;
    logic [N*DW-1:0] inp_y = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N*AW-1:0] err_sum;
    logic [CW-1:0]   row_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int msum[N];
    int mcnt;
    bit mhold;
    bit mvalid;
    bit mready;
    int exp_sum[N];
    int exp_cnt;

    mbgd_err_accum #(
        .N     (N),
        .DW    (DW),
        .BATCH (BATCH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .inp_h     (inp_h),
        .inp_y     (inp_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sum   (err_sum),
        .row_count (row_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int laneSum(input int i);
        logic [AW-1:0] s;
        s = err_sum[i*AW +: AW];
        return int'($signed(s));
    endfunction

    function automatic logic [N*DW-1:0] fillRow(input int v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    // Reference model: one step per clock edge or reset assertion
    task automatic modelStep();
        logic [DW-1:0] hv;
        logic [DW-1:0] yv;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                msum[i] = 0;
                exp_sum[i] = 0;
            end
            mcnt = 0; mhold = 0; mvalid = 0; mready = 0; exp_cnt = 0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) msum[i] = 0;
            mcnt = 0; mhold = 0; mvalid = 0; mready = 1;
        end else if (!mhold) begin
            if (in_valid && mready) begin
                for (int i = 0; i < N; i++) begin
                    hv = inp_h[i*DW +: DW];
                    yv = inp_y[i*DW +: DW];
                    msum[i] += int'($signed(hv)) - int'($signed(yv));
                end
                mcnt++;
                if (mcnt == BATCH || in_last) begin
                    for (int i = 0; i < N; i++) begin
                        exp_sum[i] = msum[i];
                        msum[i] = 0;
                    end
                    exp_cnt = mcnt;
                    mcnt = 0; mhold = 1; mvalid = 1;
                end
            end
            mready = !mhold;
        end else begin
            if (out_ready) begin
                mvalid = 0;
                mhold = 0;
            end
            mready = !mhold;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            modelStep();
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("in_ready", int'(in_ready), int'(mready));
            checkOutput("out_valid", int'(out_valid), int'(mvalid));
            if (mvalid) begin
                for (int i = 0; i < N; i++) checkOutput("err_sum_lane", laneSum(i), exp_sum[i]);
                checkOutput("row_count", int'(row_count), exp_cnt);
            end
        end
    end

    // Present one row at a negedge and keep it until it is taken
    task automatic applyStimulus(input logic [N*DW-1:0] h, input logic [N*DW-1:0] y,
                                 input logic last);
        int tries;
        inp_h = h;
        inp_y = y;
        in_last = last;
        in_valid = 1'b1;
        tries = 0;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) checkOutput("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic waitValid();
        int tries;
        tries = 0;
        while (!out_valid && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!out_valid) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_row_count"}, int'(row_count), 0);
        checkOutput({tag, "_err_sum_zero"}, int'(err_sum == '0), 1);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkZeroOutputs(tag);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [N*DW-1:0] h;
        logic [N*DW-1:0] y;

        // Reset values
        #2;
        checkZeroOutputs("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", int'(in_ready), 1);

        // Full batch of four rows
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) applyStimulus(fillRow(10), fillRow(3), 1'b0);
        checkOutput("full_valid", int'(out_valid), 1);
        for (int i = 0; i < N; i++) checkOutput("full_lane", laneSum(i), 28);
        checkOutput("full_count", int'(row_count), 4);
        checkOutput("full_bubble", int'(in_ready), 0);
        @(negedge clk);
        checkOutput("full_ready_back", int'(in_ready), 1);
        checkOutput("full_valid_drop", int'(out_valid), 0);

        // Signed extremes must not wrap
        h = '0; y = '0;
        h[7:0] = 8'h80; y[7:0] = 8'h7F;
        h[15:8] = 8'h7F; y[15:8] = 8'h80;
        for (int r = 0; r < 4; r++) applyStimulus(h, y, 1'b0);
        waitValid();
        checkOutput("ext_lane0", laneSum(0), -1020);
        checkOutput("ext_lane1", laneSum(1), 1020);
        checkOutput("ext_lane2", laneSum(2), 0);

        // Early close with in_last
        applyStimulus(fillRow(5), fillRow(1), 1'b0);
        applyStimulus(fillRow(5), fillRow(1), 1'b1);
        waitValid();
        checkOutput("early_lane", laneSum(3), 8);
        checkOutput("early_count", int'(row_count), 2);
        @(negedge clk);
        applyStimulus(fillRow(1), fillRow(0), 1'b1);
        waitValid();
        checkOutput("no_carry_lane", laneSum(5), 1);
        checkOutput("no_carry_count", int'(row_count), 1);

        // Backpressure holds the sums and blocks input
        @(negedge clk);
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) applyStimulus(fillRow(7), fillRow(-2), 1'b0);
        inp_h = fillRow(100);
        inp_y = fillRow(0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid", int'(out_valid), 1);
            checkOutput("bp_lane", laneSum(c), 36);
            checkOutput("bp_count", int'(row_count), 4);
            checkOutput("bp_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", int'(out_valid), 0);

        // clear collides with the third row
        applyStimulus(fillRow(2), fillRow(0), 1'b0);
        applyStimulus(fillRow(2), fillRow(0), 1'b0);
        inp_h = fillRow(9);
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < 4; r++) applyStimulus(fillRow(2), fillRow(0), 1'b0);
        waitValid();
        checkOutput("clear_lane", laneSum(7), 8);
        checkOutput("clear_count", int'(row_count), 4);
        @(negedge clk);

        // Async reset mid-batch and mid-hold
        applyStimulus(fillRow(50), fillRow(0), 1'b0);
        applyStimulus(fillRow(50), fillRow(0), 1'b0);
        asyncReset("rst_mid_batch");
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) applyStimulus(fillRow(3), fillRow(0), 1'b0);
        waitValid();
        asyncReset("rst_mid_hold");
        out_ready = 1'b1;
        applyStimulus(fillRow(4), fillRow(1), 1'b0);
        applyStimulus(fillRow(4), fillRow(1), 1'b0);
        applyStimulus(fillRow(4), fillRow(1), 1'b1);
        waitValid();
        checkOutput("post_reset_lane", laneSum(0), 9);
        checkOutput("post_reset_count", int'(row_count), 3);
        @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            inp_h     = {$urandom, $urandom};
            inp_y     = {$urandom, $urandom};
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
